// File: rtl/heater_ramp_ctrl_pkg.sv
// Shared types and defaults for the heater turn-on sequencer.
// Consumers: heater_ramp_ctrl_if, heater_ramp_timer, heater_ramp_ctrl.
package heater_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } heater_state_e;

  localparam int HEATER_N           = 16;
  localparam int HEATER_MAX_ON      = 8;
  localparam int HEATER_RAMP_CYCLES = 1024;

  // Isolates the lowest set bit; callers widen to 64 bits, so N is limited to 64.
  function automatic logic [63:0] lowest_set_onehot(input logic [63:0] v);
    return v & (~v + 64'd1);
  endfunction

endpackage

// File: rtl/heater_ramp_ctrl_if.sv
// Request/grant bundle between the VIO-side requester and heater_ramp_ctrl.
interface heater_ramp_ctrl_if
  import heater_pkg::*;
#(
  parameter int N = HEATER_N
);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  req_enable;
  logic [N-1:0]  heater_error;
  logic [N-1:0]  heater_enable;
  logic [CW-1:0] on_count;
  logic          ramping;
  logic          limited;
  logic [N-1:0]  fault;

  modport master (
    output req_enable, heater_error,
    input  heater_enable, on_count, ramping, limited, fault
  );

  modport slave (
    input  req_enable, heater_error,
    output heater_enable, on_count, ramping, limited, fault
  );

endinterface

// File: rtl/heater_ramp_ctrl_timer.sv
// Loadable down-counter setting the spacing between successive heater turn-ons.
module heater_ramp_timer
  import heater_pkg::*;
#(
  parameter int RAMP_CYCLES = HEATER_RAMP_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  output logic [$clog2(RAMP_CYCLES)-1:0] value,
  output logic                           done
);
  localparam int TW = $clog2(RAMP_CYCLES);

  logic [TW-1:0] count_r;

  // Load RAMP_CYCLES-1, then count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {TW{1'b0}};
    end else if (load) begin
      count_r <= TW'(RAMP_CYCLES - 1);
    end else if (count_r != {TW{1'b0}}) begin
      count_r <= count_r - TW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // The count reaches zero on the coming edge, so grants stay exactly RAMP_CYCLES apart.
  assign done  = (count_r <= TW'(1));
  assign value = count_r;

endmodule

// File: rtl/heater_ramp_ctrl.sv
// Heater turn-on sequencer with MAX_ON current cap and RAMP_CYCLES grant spacing.
// Optional macro HEATER_ERR_SHUTDOWN_EN enables sticky per-channel error shutdown.
module heater_ramp_ctrl
  import heater_pkg::*;
#(
  parameter int N           = HEATER_N,
  parameter int MAX_ON      = HEATER_MAX_ON,
  parameter int RAMP_CYCLES = HEATER_RAMP_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  heater_ramp_ctrl_if.slave  bus
);
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(RAMP_CYCLES);

  heater_state_e state_r;
  logic [N-1:0]  en_r, fault_r;
  logic [CW-1:0] cnt_r;
  logic          ramping_r, limited_r;

  logic [N-1:0]  trip_s, kept_s, pending_s, grant_s, en_next_s, fault_next_s;
  logic [CW-1:0] kept_cnt_s;
  logic          timer_load_s, timer_done_s;
  logic [TW-1:0] timer_value_unused_s;

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = {CW{1'b0}};
    for (int i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

`ifndef HEATER_ERR_SHUTDOWN_EN
  logic unused_heater_error_s;
  assign unused_heater_error_s = ^bus.heater_error;
`endif

  // Turn-offs first, then at most one grant judged against the post-turn-off count.
  always_comb begin
    trip_s       = {N{1'b0}};
    fault_next_s = {N{1'b0}};
`ifdef HEATER_ERR_SHUTDOWN_EN
    trip_s       = bus.heater_error & en_r;
    fault_next_s = (fault_r | trip_s) & bus.req_enable;
`endif
    kept_s     = en_r & bus.req_enable & ~trip_s;
    pending_s  = bus.req_enable & ~en_r & ~fault_r;
    kept_cnt_s = popcount(kept_s);
    if ((state_r == IDLE) && (pending_s != {N{1'b0}}) && (kept_cnt_s < CW'(MAX_ON))) begin
      grant_s = N'(lowest_set_onehot(64'(pending_s)));
    end else begin
      grant_s = {N{1'b0}};
    end
    en_next_s    = kept_s | grant_s;
    timer_load_s = (grant_s != {N{1'b0}});
  end

  heater_ramp_timer #(
    .RAMP_CYCLES (RAMP_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load_s),
    .value (timer_value_unused_s),
    .done  (timer_done_s)
  );

  // Sequencer FSM plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      en_r      <= {N{1'b0}};
      fault_r   <= {N{1'b0}};
      cnt_r     <= {CW{1'b0}};
      ramping_r <= 1'b0;
      limited_r <= 1'b0;
    end else begin
      en_r      <= en_next_s;
      fault_r   <= fault_next_s;
      cnt_r     <= popcount(en_next_s);
      limited_r <= (pending_s != {N{1'b0}}) && (kept_cnt_s == CW'(MAX_ON));
      case (state_r)
        IDLE: begin
          if (timer_load_s) begin
            state_r   <= WAIT;
            ramping_r <= 1'b1;
          end else begin
            state_r   <= IDLE;
            ramping_r <= 1'b0;
          end
        end
        WAIT: begin
          if (timer_done_s) begin
            state_r   <= IDLE;
            ramping_r <= 1'b0;
          end else begin
            state_r   <= WAIT;
            ramping_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          ramping_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.heater_enable = en_r;
  assign bus.fault         = fault_r;
  assign bus.on_count      = cnt_r;
  assign bus.ramping       = ramping_r;
  assign bus.limited       = limited_r;

endmodule

// File: tb/tb_heater_ramp_ctrl.sv
// Self-checking bench for heater_ramp_ctrl (N=16, MAX_ON=4, RAMP_CYCLES=8).
module tb_heater_ramp_ctrl;
  localparam int N  = 16;
  localparam int MO = 4;
  localparam int RC = 8;
`ifdef HEATER_ERR_SHUTDOWN_EN
  localparam bit SHUT = 1'b1;
`else
  localparam bit SHUT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  heater_ramp_ctrl_if #(.N(N)) bus ();

  heater_ramp_ctrl #(.N(N), .MAX_ON(MO), .RAMP_CYCLES(RC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: channel set, fault set, edges elapsed since the latest grant.
  logic [15:0] m_en, m_fault;
  logic        m_ramp, m_lim;
  int          m_since;

  task automatic model_reset();
    m_en = 16'h0; m_fault = 16'h0; m_ramp = 1'b0; m_lim = 1'b0; m_since = RC;
  endtask

  task automatic model_edge(input logic [15:0] req, input logic [15:0] err);
    logic [15:0] kept, pend, nf;
    int k;
    kept = m_en & req;
    nf   = 16'h0;
    if (SHUT) begin
      kept = kept & ~(err & m_en);
      nf   = (m_fault | (err & m_en)) & req;
    end
    pend  = req & ~m_en & ~m_fault;
    k     = (m_since >= RC) ? RC : m_since + 1;
    m_lim = (pend != 16'h0) && ($countones(kept) == MO);
    if ((pend != 16'h0) && ($countones(kept) < MO) && (k >= RC)) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          kept[i] = 1'b1;
          break;
        end
      end
      k = 0;
    end
    m_en    = kept;
    m_fault = nf;
    m_since = k;
    m_ramp  = (k < RC - 1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".en"},    32'(bus.heater_enable), 32'(m_en));
    chk({tag, ".cnt"},   32'(bus.on_count),      32'($countones(m_en)));
    chk({tag, ".ramp"},  32'(bus.ramping),       32'(m_ramp));
    chk({tag, ".lim"},   32'(bus.limited),       32'(m_lim));
    chk({tag, ".fault"}, 32'(bus.fault),         32'(m_fault));
  endtask

  task automatic step(input logic [15:0] req, input logic [15:0] err);
    bus.req_enable   = req;
    bus.heater_error = err;
    @(posedge clk);
    model_edge(req, err);
    #1;
  endtask

  task automatic run(input logic [15:0] req, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(req, 16'h0);
      chk_model(tag);
    end
  endtask

  typedef struct {
    logic [15:0] req;
    int          cycles;
    logic [15:0] en;
    logic [4:0]  cnt;
    logic        ramp;
    logic        lim;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [15:0] rq, er;

    vt[0]  = '{16'hFFFF,  1, 16'h0001, 5'd1, 1'b1, 1'b0};
    vt[1]  = '{16'hFFFF,  7, 16'h0001, 5'd1, 1'b0, 1'b0};
    vt[2]  = '{16'hFFFF,  1, 16'h0003, 5'd2, 1'b1, 1'b0};
    vt[3]  = '{16'hFFFF, 16, 16'h000F, 5'd4, 1'b1, 1'b0};
    vt[4]  = '{16'hFFFF,  8, 16'h000F, 5'd4, 1'b0, 1'b1};
    vt[5]  = '{16'hFFFF, 20, 16'h000F, 5'd4, 1'b0, 1'b1};
    vt[6]  = '{16'hFFFD,  1, 16'h001D, 5'd4, 1'b1, 1'b0};
    vt[7]  = '{16'hFFFD,  8, 16'h001D, 5'd4, 1'b0, 1'b1};
    vt[8]  = '{16'h0000,  1, 16'h0000, 5'd0, 1'b0, 1'b0};
    vt[9]  = '{16'h000F,  1, 16'h0001, 5'd1, 1'b1, 1'b0};
    vt[10] = '{16'h0000,  1, 16'h0000, 5'd0, 1'b1, 1'b0};
    vt[11] = '{16'h0000,  5, 16'h0000, 5'd0, 1'b1, 1'b0};
    vt[12] = '{16'h0000,  1, 16'h0000, 5'd0, 1'b0, 1'b0};
    vt[13] = '{16'h0000,  3, 16'h0000, 5'd0, 1'b0, 1'b0};

    // Reset held with every channel requested.
    bus.req_enable   = 16'hFFFF;
    bus.heater_error = 16'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_model("reset");
    rst_n = 1'b1;

    foreach (vt[v]) begin
      run(vt[v].req, vt[v].cycles, "tbl_model");
      chk($sformatf("tbl%0d.en", v),   32'(bus.heater_enable), 32'(vt[v].en));
      chk($sformatf("tbl%0d.cnt", v),  32'(bus.on_count),      32'(vt[v].cnt));
      chk($sformatf("tbl%0d.ramp", v), 32'(bus.ramping),       32'(vt[v].ramp));
      chk($sformatf("tbl%0d.lim", v),  32'(bus.limited),       32'(vt[v].lim));
      chk($sformatf("tbl%0d.fault", v), 32'(bus.fault),        32'h0);
    end

    // Error pulse on channel 2, hold, then drop/raise request to clear.
    run(16'h0007, 30, "err_ramp");
    chk("err_pre.en", 32'(bus.heater_enable), 32'h0007);
    step(16'h0007, 16'h0004);
    chk_model("err_pulse");
    chk("err_pulse.en",    32'(bus.heater_enable), SHUT ? 32'h0003 : 32'h0007);
    chk("err_pulse.fault", 32'(bus.fault),         SHUT ? 32'h0004 : 32'h0000);
    run(16'h0007, 20, "err_hold");
    chk("err_hold.en", 32'(bus.heater_enable), SHUT ? 32'h0003 : 32'h0007);
    run(16'h0003, 1, "err_drop");
    chk("err_drop.fault", 32'(bus.fault), 32'h0);
    run(16'h0007, 1, "err_regrant");
    chk("err_regrant.en", 32'(bus.heater_enable), 32'h0007);
    run(16'h0007, 9, "err_tail");

    // Asynchronous reset in the middle of a spacing window.
    run(16'h0000, 10, "ar_clear");
    run(16'h0007, 18, "ar_ramp");
    chk("ar_pre.en", 32'(bus.heater_enable), 32'h0007);
    chk("ar_pre.ramp", 32'(bus.ramping), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk_model("ar_async");
    chk("ar_async.en", 32'(bus.heater_enable), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(16'h0007, 16'h0);
    chk_model("ar_release");
    chk("ar_release.en", 32'(bus.heater_enable), 32'h0001);

    // Randomized requests and sparse error pulses against the model.
    rq = 16'h0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) rq = 16'($urandom);
      else if ($urandom_range(0, 3) == 0) rq = rq ^ (16'h1 << $urandom_range(0, 15));
      er = ($urandom_range(0, 11) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
      step(rq, er);
      chk_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/heater_ramp_ctrl.md
# heater_ramp_ctrl

Turn-on sequencer and current limiter placed directly upstream of the heater array. It takes a requested per-channel enable mask from the VIO and drives each channel's heater enable. Channels turn on one at a time with a fixed spacing, and the number of channels on at once is capped. This prevents the supply inrush and overcurrent that reconfigure the FPGA when all channels are enabled together.

## Interface
- N, 16: number of heater channels.
- MAX_ON, 8: maximum channels enabled simultaneously (1..N).
- RAMP_CYCLES, 1024: minimum clk cycles between successive turn-ons (>=2).
- clk  in  1  heater clock (300 MHz domain, same as heaters).
- rst_n  in  1  reset, asynchronous, active-low.
- req_enable  in  N  requested enables (already in clk domain).
- heater_error  in  N  per-channel error from heaters.
- heater_enable  out  N  granted enables, registered.
- on_count  out  $clog2(N+1)  popcount of heater_enable, registered.
- ramping  out  1  high while spacing timer runs.
- limited  out  1  pending request blocked by MAX_ON.
- fault  out  N  sticky error-shutdown flags (zero when feature compiled out).

## Operation
- Reset values: heater_enable=0, on_count=0, ramping=0, limited=0, fault=0, timer=0, state IDLE.
- pending = req_enable & ~heater_enable & ~fault.
- Turn-off is immediate: any bit with req_enable low clears at the next edge, in any state.
- Effective count = popcount of heater_enable after this edge's turn-offs. Grant decisions use this value, so a drop and a grant can occur on the same edge.
- FSM IDLE:
  - If pending != 0 and effective count < MAX_ON, set the lowest-index pending bit, load timer with RAMP_CYCLES-1, and go to WAIT.
  - Otherwise stay in IDLE.
- FSM WAIT: decrement timer each cycle. When timer==0, go to IDLE. No grants occur in WAIT. Request changes do not restart or abort the timer.
- ramping = (state==WAIT).
- limited = (pending != 0) and (effective count == MAX_ON). Registered.
- on_count is updated on the same edge as heater_enable.
- Timer width is $clog2(RAMP_CYCLES). Down-counter, no wrap: it is loaded only in IDLE.
- Reset asserted mid-operation clears everything asynchronously. On release, ramping restarts from IDLE.

## Timing
- Grant latency: a pending bit sampled in IDLE is high on heater_enable after that edge (1 cycle).
- Consecutive grants are exactly RAMP_CYCLES cycles apart when requests remain pending.
- Turn-off latency: 1 edge after req_enable is sampled low.
- Error shutdown latency (macro on): heater_enable[i] is low 1 edge after heater_error[i] is sampled high.

## Configuration
- HEATER_ERR_SHUTDOWN_EN defined:
  - heater_error[i] sampled high while heater_enable[i]=1 sets fault[i] and clears heater_enable[i] on the same edge.
  - fault[i] clears only when req_enable[i] is sampled low.
  - A faulted channel is excluded from pending.
- Not defined: heater_error is ignored, fault is tied to 0, and the ports remain present for uniform instantiation.

## Structure
- Shared package heater_pkg holds:
  - the state enum (IDLE, WAIT);
  - default constants HEATER_N=16, HEATER_MAX_ON=8, HEATER_RAMP_CYCLES=1024;
  - a lowest-set-bit one-hot function.
- One sub-module, heater_ramp_timer: loadable down-counter with load, value, and done outputs, parameterised by RAMP_CYCLES.
- Popcount and grant logic stay in the top.

## Test plan
All scenarios use N=16, MAX_ON=4, RAMP_CYCLES=8.
- Reset with req_enable=16'hFFFF held: all outputs 0. After release, bit0 is granted on the first edge.
- req=16'hFFFF from IDLE: bits 0,1,2,3 rise at cycles 1, 9, 17, 25. After that, on_count=4, limited=1, and bit4 is never granted.
- With 4 channels on, drop req[1]: heater_enable[1]=0 next edge and on_count=3. bit4 is granted on the first IDLE edge, on the same edge if already in IDLE.
- req goes from 16'h000F to 0 mid-WAIT: all enables clear next edge, ramping stays high until the timer expires, and no grant follows.
- Macro on, req=16'h0007 ramped up, heater_error[2] pulsed 1 cycle: enable[2]=0 and fault[2]=1 next edge. There is no regrant while req[2] stays high. req[2] low then high clears fault[2], and the channel is granted again after spacing.
- rst_n asserted asynchronously mid-WAIT with 3 channels on: outputs are 0 immediately without a clock. After release, the ramp restarts from bit0.
